// File: rtl/i_cache_fill.sv
// Direct-mapped instruction cache with whole-block refill over a per-word req/ack handshake.
// Hits are served combinationally in IDLE; a miss stalls fetch until the latched block is refilled.
module i_cache_fill #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int NUM_BLKS  = 32,
  parameter int BLK_WORDS = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = $clog2(NUM_BLKS);
  localparam int OFF_W = $clog2(BLK_WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]          state;
  logic [NUM_BLKS-1:0] valid;
  logic [TAG_W-1:0]    tag_arr  [NUM_BLKS];
  logic [DATA_W-1:0]   data_arr [NUM_BLKS*BLK_WORDS];
  logic [TAG_W-1:0]    lat_tag;
  logic [IDX_W-1:0]    lat_idx;
  logic [OFF_W-1:0]    fill_cnt;

  logic [OFF_W-1:0] cpu_off;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic             hit;
  logic             hit_ev;
  logic             miss_start;
  logic             word_ack;
  logic             last_ack;

  assign cpu_off = cpu_addr[OFF_W-1:0];
  assign cpu_idx = cpu_addr[OFF_W +: IDX_W];
  assign cpu_tag = cpu_addr[ADDR_W-1 -: TAG_W];

  assign hit        = (state == IDLE) && valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
  assign hit_ev     = cpu_rd && hit;
  // A miss coinciding with flush does not start a fill; the retried fetch misses next cycle.
  assign miss_start = (state == IDLE) && cpu_rd && !hit && !flush;
  assign word_ack   = (state == FILL) && mem_ack;
  assign last_ack   = word_ack && (fill_cnt == OFF_W'(BLK_WORDS - 1));

  assign cpu_data  = data_arr[{cpu_idx, cpu_off}];
  // Gated with rst so the stall drops the moment reset is asserted, even with cpu_rd held.
  assign cpu_stall = !rst && ((state == FILL) || (cpu_rd && !hit));
  assign mem_req   = (state == FILL);
  assign mem_addr  = {lat_tag, lat_idx, fill_cnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      lat_tag  <= '0;
      lat_idx  <= '0;
      fill_cnt <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_ev && (hit_cnt != '1))
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (miss_start && (miss_cnt != '1))
        miss_cnt <= miss_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (miss_start) begin
            state    <= FILL;
            lat_tag  <= cpu_tag;
            lat_idx  <= cpu_idx;
            fill_cnt <= '0;
          end
        end
        FILL: begin
          if (flush) begin
            state    <= IDLE;
            fill_cnt <= '0;
          end else if (mem_ack) begin
            fill_cnt <= fill_cnt + OFF_W'(1);
            if (last_ack) begin
              state          <= IDLE;
              valid[lat_idx] <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Flush overrides any valid bit set by a final ack in the same cycle.
      if (flush)
        valid <= '0;
    end
  end

  // Words written before an aborted fill are kept; the block's valid bit guards them.
  always_ff @(posedge clk) begin
    if (word_ack)
      data_arr[{lat_idx, fill_cnt}] <= mem_data;
    if (last_ack)
      tag_arr[lat_idx] <= lat_tag;
  end

endmodule

// File: tb/tb_i_cache_fill.sv
// Directed bench for i_cache_fill: table-driven hit reads plus hand-written fill, flush
// and reset sequences against a memory model returning addr ^ 16'hA5C3.
module tb_i_cache_fill;

  localparam logic [15:0] KEY = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rd = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_data;
  logic        cpu_stall;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  logic        s_rd = 1'b0;
  logic [15:0] s_addr = '0;
  logic [15:0] s_data;
  logic        s_stall;
  logic        s_flush = 1'b0;
  logic        s_req;
  logic [15:0] s_mem_addr;
  logic        s_ack = 1'b1;
  logic [15:0] s_mem_data;
  logic [3:0]  s_hit_cnt;
  logic [3:0]  s_miss_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic        exp_stall;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  assign mem_data   = mem_addr ^ KEY;
  assign s_mem_data = s_mem_addr ^ KEY;

  i_cache_fill dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_stall(cpu_stall), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Narrow-counter instance used only to reach saturation in a few dozen cycles.
  i_cache_fill #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .cpu_rd(s_rd), .cpu_addr(s_addr), .cpu_data(s_data),
    .cpu_stall(s_stall), .flush(s_flush), .mem_req(s_req), .mem_addr(s_mem_addr),
    .mem_ack(s_ack), .mem_data(s_mem_data), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  function automatic logic [15:0] expWord(input logic [15:0] a);
    return a ^ KEY;
  endfunction

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic [15:0] addr,
                               input logic ack, input logic fl);
    cpu_rd   = rd;
    cpu_addr = addr;
    mem_ack  = ack;
    flush    = fl;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Acks nwords words (gap idle cycles before each ack) and checks the request address per cycle.
  task automatic fillBlock(input logic [15:0] base, input int gap, input int nwords,
                           output int req_seen);
    req_seen = 0;
    for (int w = 0; w < nwords; w++) begin
      for (int g = 0; g <= gap; g++) begin
        nextCycle();
        mem_ack = (g == gap);
        #1;
        if (mem_req === 1'b1) req_seen++;
        checkOutput("fill_addr", 32'(mem_addr), 32'({base[15:3], 3'(w)}));
        checkOutput("fill_stall", 32'(cpu_stall), 32'd1);
      end
    end
  endtask

  task automatic missFill(input logic [15:0] addr, input int gap);
    int seen;
    nextCycle();
    applyStimulus(1'b1, addr, 1'b0, 1'b0);
    checkOutput("miss_stall", 32'(cpu_stall), 32'd1);
    fillBlock({addr[15:3], 3'b000}, gap, 8, seen);
    checkOutput("fill_cycles", 32'(seen), 32'(8 * (gap + 1)));
    nextCycle();
    applyStimulus(1'b1, addr, 1'b0, 1'b0);
    checkOutput("retry_stall", 32'(cpu_stall), 32'd0);
    checkOutput("retry_data", 32'(cpu_data), 32'(expWord(addr)));
    checkOutput("retry_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 8; i++) begin
      vecs[i].rd        = 1'b1;
      vecs[i].addr      = 16'h1230 + 16'(i);
      vecs[i].exp_stall = 1'b0;
      vecs[i].exp_data  = expWord(16'h1230 + 16'(i));
    end
    vecs[8].rd        = 1'b0;
    vecs[8].addr      = 16'h7777;
    vecs[8].exp_stall = 1'b0;
    vecs[8].exp_data  = 16'h0000;

    // Reset state
    nextCycle();
    checkOutput("rst_stall", 32'(cpu_stall), 32'd0);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    checkOutput("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    nextCycle();
    rst = 1'b0;

    // Cold miss on 0x1234 and full back-to-back refill
    missFill(16'h1234, 0);
    checkOutput("t1_miss_cnt", 32'(miss_cnt), 32'd1);

    // Hit reads across the whole block
    for (int i = 0; i < 9; i++) begin
      nextCycle();
      applyStimulus(vecs[i].rd, vecs[i].addr, 1'b0, 1'b0);
      checkOutput("vec_stall", 32'(cpu_stall), 32'(vecs[i].exp_stall));
      if (vecs[i].rd)
        checkOutput("vec_data", 32'(cpu_data), 32'(vecs[i].exp_data));
    end
    checkOutput("t2_hit_cnt", 32'(hit_cnt), 32'd9);
    checkOutput("t2_miss_cnt", 32'(miss_cnt), 32'd1);

    // Conflict eviction on index 6
    missFill(16'h5234, 0);
    missFill(16'h1234, 0);
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("t3_miss_cnt", 32'(miss_cnt), 32'd3);
    checkOutput("t3_hit_cnt", 32'(hit_cnt), 32'd11);

    // Slow memory: two idle cycles before every ack
    missFill(16'h2A45, 2);
    nextCycle();
    applyStimulus(1'b1, 16'h2A40, 1'b0, 1'b0);
    checkOutput("t4_stall", 32'(cpu_stall), 32'd0);
    checkOutput("t4_data", 32'(cpu_data), 32'(expWord(16'h2A40)));
    nextCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("t4_hit_cnt", 32'(hit_cnt), 32'd13);
    checkOutput("t4_miss_cnt", 32'(miss_cnt), 32'd4);

    // Flush after the 3rd ack aborts the fill
    nextCycle();
    applyStimulus(1'b1, 16'h3300, 1'b0, 1'b0);
    checkOutput("t5_miss_stall", 32'(cpu_stall), 32'd1);
    fillBlock(16'h3300, 0, 3, seen);
    nextCycle();
    applyStimulus(1'b1, 16'h3300, 1'b0, 1'b1);
    checkOutput("t5_req_in_flush", 32'(mem_req), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 16'h3300, 1'b0, 1'b0);
    checkOutput("t5_req_after_flush", 32'(mem_req), 32'd0);
    checkOutput("t5_addr_after_flush", 32'(mem_addr), 32'h3300);
    checkOutput("t5_restall", 32'(cpu_stall), 32'd1);
    fillBlock(16'h3300, 0, 8, seen);
    nextCycle();
    applyStimulus(1'b1, 16'h3300, 1'b0, 1'b0);
    checkOutput("t5_retry_stall", 32'(cpu_stall), 32'd0);
    checkOutput("t5_retry_data", 32'(cpu_data), 32'(expWord(16'h3300)));
    nextCycle();
    applyStimulus(1'b1, 16'h2A40, 1'b0, 1'b0);
    checkOutput("t5_flushed_2a40", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b0, 16'h2A40, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
    checkOutput("t5_flushed_1234", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b0, 16'h1234, 1'b0, 1'b0);

    // A hit in the flush cycle still returns data and counts
    nextCycle();
    applyStimulus(1'b1, 16'h3302, 1'b0, 1'b1);
    checkOutput("flush_hit_stall", 32'(cpu_stall), 32'd0);
    checkOutput("flush_hit_data", 32'(cpu_data), 32'(expWord(16'h3302)));
    nextCycle();
    applyStimulus(1'b1, 16'h3302, 1'b0, 1'b0);
    checkOutput("flush_hit_gone", 32'(cpu_stall), 32'd1);

    // Flush together with the final ack leaves the block invalid
    fillBlock(16'h3300, 0, 7, seen);
    nextCycle();
    applyStimulus(1'b1, 16'h3302, 1'b1, 1'b1);
    checkOutput("last_ack_addr", 32'(mem_addr), 32'h3307);
    checkOutput("last_ack_req", 32'(mem_req), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 16'h3302, 1'b0, 1'b0);
    checkOutput("last_ack_flush_req", 32'(mem_req), 32'd0);
    checkOutput("last_ack_flush_stall", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b0, 16'h3302, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t5_hit_cnt", 32'(hit_cnt), 32'd15);
    checkOutput("t5_miss_cnt", 32'(miss_cnt), 32'd7);

    // Asynchronous reset in the middle of a fill
    nextCycle();
    applyStimulus(1'b1, 16'h4410, 1'b0, 1'b0);
    checkOutput("t6_miss_stall", 32'(cpu_stall), 32'd1);
    fillBlock(16'h4410, 0, 2, seen);
    nextCycle();
    mem_ack = 1'b0;
    #1;
    checkOutput("t6_req_mid_fill", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_stall", 32'(cpu_stall), 32'd0);
    checkOutput("t6_rst_req", 32'(mem_req), 32'd0);
    checkOutput("t6_rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("t6_rst_hit_cnt", 32'(hit_cnt), 32'd0);
    checkOutput("t6_rst_miss_cnt", 32'(miss_cnt), 32'd0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("t6_partial_invalid", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    // Counter saturation on the narrow-counter instance (ack held high throughout)
    nextCycle();
    s_rd   = 1'b1;
    s_addr = 16'h0010;
    for (int c = 0; c < 30; c++) nextCycle();
    checkOutput("sat_stall", 32'(s_stall), 32'd0);
    checkOutput("sat_data", 32'(s_data), 32'(expWord(16'h0010)));
    checkOutput("sat_hit_cnt", 32'(s_hit_cnt), 32'hF);
    checkOutput("sat_miss_cnt", 32'(s_miss_cnt), 32'd1);
    s_rd = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
